// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexes four BCD digits (plus decimal points) onto a
//   common-anode 4-digit 7-segment display with shared segment lines.
//   Each digit slot lasts TICKS_PER_DIGIT cycles. The first BLANK_TICKS
//   cycles of a slot keep every anode off, which prevents ghosting.
//   Digits, dp and lz_en are snapshotted once per frame at the start of
//   slot 0, so the display never tears. blank_all is applied live.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   digits     four BCD digits, [3:0] = digit 0 (rightmost)
//   dp_in      decimal-point request per digit, active-high
//   lz_en      leading-zero suppression enable
//   blank_all  forces the display dark while high
//   an         anode enables, active-low, an[i] drives digit i
//   seg        segments, active-low, seg[7] = dp, seg[6:0] = g..a
//   scan_idx   digit slot currently in progress
module seg_scan_driver #(
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_TICKS     = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    input  logic        blank_all,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [1:0]  scan_idx
);

    localparam int unsigned CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] TICK_SHOW = CW'(BLANK_TICKS);

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    scan_idx_q, scan_idx_d;
    logic [3:0]    snap_dig_q [4];
    logic [3:0]    snap_dp_q;
    logic          snap_lz_q;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          frame_start;
    logic [3:0]    sup;
    logic [3:0]    cur_dig;

    function automatic logic [6:0] decode7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'b1000000;
            4'd1:    r = 7'b1111001;
            4'd2:    r = 7'b0100100;
            4'd3:    r = 7'b0110000;
            4'd4:    r = 7'b0011001;
            4'd5:    r = 7'b0010010;
            4'd6:    r = 7'b0000010;
            4'd7:    r = 7'b1111000;
            4'd8:    r = 7'b0000000;
            4'd9:    r = 7'b0010000;
            default: r = 7'b1111111;
        endcase
        return r;
    endfunction

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end
    end

    assign frame_start = (tick_cnt_q == '0) && (scan_idx_q == 2'd0);

    // A digit is a leading zero only if it and every more-significant
    // digit are zero; the chain runs from digit 3 downwards.
    always_comb begin
        sup    = '0;
        sup[3] = snap_lz_q && (snap_dig_q[3] == 4'd0);
        sup[2] = sup[3] && (snap_dig_q[2] == 4'd0);
        sup[1] = sup[2] && (snap_dig_q[1] == 4'd0);
        sup[0] = 1'b0;
    end

    assign cur_dig = snap_dig_q[scan_idx_q];

    always_comb begin
        an_d  = '1;
        seg_d = '1;
        if (!blank_all && (tick_cnt_q >= TICK_SHOW)) begin
            an_d             = ~(4'b0001 << scan_idx_q);
            seg_d[7]         = ~snap_dp_q[scan_idx_q];
            seg_d[6:0]       = sup[scan_idx_q] ? 7'b1111111 : decode7(cur_dig);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            scan_idx_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                snap_dig_q[i] <= '0;
            end
            snap_dp_q  <= '0;
            snap_lz_q  <= 1'b0;
            an_q       <= '1;
            seg_q      <= '1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_idx_q <= scan_idx_d;
            if (frame_start) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    snap_dig_q[i] <= digits[4*i +: 4];
                end
                snap_dp_q <= dp_in;
                snap_lz_q <= lz_en;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int T     = 10;
    localparam int B     = 2;
    localparam int FRAME = 4 * T;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;
    logic        blank_all = 1'b0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  scan_idx;

    seg_scan_driver #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .dp_in     (dp_in),
        .lz_en     (lz_en),
        .blank_all (blank_all),
        .an        (an),
        .seg       (seg),
        .scan_idx  (scan_idx)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int n      = 0;
    logic [15:0] m_dig = '0;
    logic [3:0]  m_dp  = '0;
    logic        m_lz  = 1'b0;
    logic [13:0] sb [$];   // {scan_idx, an, seg} expected after each edge
    logic [13:0] exp_v;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected outputs after edge e (edges counted from reset release).
    function automatic logic [13:0] model_out(input int e, input logic [15:0] d,
                                              input logic [3:0] dp, input logic lz,
                                              input logic blk);
        int t, s, top;
        logic [3:0] a;
        logic [7:0] sg;
        logic [3:0] v;
        t  = (e - 1) % T;
        s  = ((e - 1) / T) % 4;
        a  = 4'hF;
        sg = 8'hFF;
        if (!blk && t >= B) begin
            top = -1;
            for (int i = 0; i < 4; i++) if (d[4*i +: 4] != 4'd0) top = i;
            a[s]     = 1'b0;
            v        = d[4*s +: 4];
            sg[7]    = ~dp[s];
            sg[6:0]  = (lz && s > 0 && s > top) ? 7'h7F : glyph(v);
        end
        return {2'((e / T) % 4), a, sg};
    endfunction

    task automatic latch_model();
        if ((n - 1) % FRAME == 0) begin
            m_dig = digits;
            m_dp  = dp_in;
            m_lz  = lz_en;
        end
    endtask

    task automatic push_model();
        n++;
        sb.push_back(model_out(n, m_dig, m_dp, m_lz, blank_all));
        latch_model();
    endtask

    task automatic push_lit(input logic [3:0] a, input logic [7:0] sg, input logic [1:0] idx);
        n++;
        sb.push_back({idx, a, sg});
        latch_model();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        n     = 0;
        m_dig = '0;
        m_dp  = '0;
        m_lz  = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        digits = 16'h9876;
        dp_in = 4'hF;
        repeat (3) tick();
        total++;
        if (an !== 4'hF) $display("FAIL reset_an: got %b expected 1111", an); else passed++;
        total++;
        if (seg !== 8'hFF) $display("FAIL reset_seg: got %h expected ff", seg); else passed++;
        total++;
        if (scan_idx !== 2'd0) $display("FAIL reset_idx: got %0d expected 0", scan_idx); else passed++;
    endtask

    task automatic test_basic();
        logic [3:0] a;
        logic [7:0] sg;
        logic [1:0] idx;
        do_reset();
        digits = 16'h1234;
        dp_in  = 4'h0;
        lz_en  = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            if (e <= 20) begin
                a   = (e <= 2) ? 4'hF : (e <= 10) ? 4'hE : (e <= 12) ? 4'hF : 4'hD;
                sg  = (e >= 3 && e <= 10) ? 8'b10011001 :
                      (e >= 13) ? 8'b10110000 : 8'hFF;
                idx = (e < 10) ? 2'd0 : (e < 20) ? 2'd1 : 2'd2;
                push_lit(a, sg, idx);
            end else begin
                push_model();
            end
            tick();
            exp_v = sb.pop_front();
            total++;
            if ({scan_idx, an, seg} !== exp_v)
                $display("FAIL basic edge %0d: got idx=%0d an=%b seg=%b, expected idx=%0d an=%b seg=%b",
                         e, scan_idx, an, seg, exp_v[13:12], exp_v[11:8], exp_v[7:0]);
            else passed++;
        end
    endtask

    task automatic test_lz();
        do_reset();
        digits = 16'h0007;
        dp_in  = 4'h0;
        lz_en  = 1'b1;
        for (int e = 1; e <= 81; e++) begin
            if (e == 41) lz_en = 1'b0;
            push_model();
            tick();
            exp_v = sb.pop_front();
            total++;
            if ({scan_idx, an, seg} !== exp_v)
                $display("FAIL lz edge %0d: got idx=%0d an=%b seg=%b, expected idx=%0d an=%b seg=%b",
                         e, scan_idx, an, seg, exp_v[13:12], exp_v[11:8], exp_v[7:0]);
            else passed++;
        end
    endtask

    task automatic test_dp();
        do_reset();
        digits = 16'h0205;
        dp_in  = 4'b0010;
        lz_en  = 1'b1;
        for (int e = 1; e <= 41; e++) begin
            push_model();
            tick();
            exp_v = sb.pop_front();
            total++;
            if ({scan_idx, an, seg} !== exp_v)
                $display("FAIL dp edge %0d: got idx=%0d an=%b seg=%b, expected idx=%0d an=%b seg=%b",
                         e, scan_idx, an, seg, exp_v[13:12], exp_v[11:8], exp_v[7:0]);
            else passed++;
        end
        dp_in = 4'h0;
    endtask

    task automatic test_tear();
        do_reset();
        digits = 16'h1111;
        lz_en  = 1'b0;
        for (int e = 1; e <= 81; e++) begin
            if (e == 16) digits = 16'h2222;
            push_model();
            tick();
            exp_v = sb.pop_front();
            total++;
            if ({scan_idx, an, seg} !== exp_v)
                $display("FAIL tear edge %0d: got idx=%0d an=%b seg=%b, expected idx=%0d an=%b seg=%b",
                         e, scan_idx, an, seg, exp_v[13:12], exp_v[11:8], exp_v[7:0]);
            else passed++;
        end
    endtask

    task automatic test_blank();
        do_reset();
        digits = 16'h5678;
        for (int e = 1; e <= 41; e++) begin
            blank_all = (e >= 14 && e <= 18);
            push_model();
            tick();
            exp_v = sb.pop_front();
            total++;
            if ({scan_idx, an, seg} !== exp_v)
                $display("FAIL blank edge %0d: got idx=%0d an=%b seg=%b, expected idx=%0d an=%b seg=%b",
                         e, scan_idx, an, seg, exp_v[13:12], exp_v[11:8], exp_v[7:0]);
            else passed++;
        end
        blank_all = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        digits = 16'h1234;
        for (int e = 1; e <= 25; e++) begin
            push_model();
            tick();
            exp_v = sb.pop_front();
            total++;
            if ({scan_idx, an, seg} !== exp_v)
                $display("FAIL pre_rst edge %0d: got idx=%0d an=%b seg=%b, expected idx=%0d an=%b seg=%b",
                         e, scan_idx, an, seg, exp_v[13:12], exp_v[11:8], exp_v[7:0]);
            else passed++;
        end
        rst    = 1'b1;
        digits = 16'hABCF;
        push_lit(4'hF, 8'hFF, 2'd0);
        tick();
        exp_v = sb.pop_front();
        total++;
        if ({scan_idx, an, seg} !== exp_v)
            $display("FAIL mid_rst: got idx=%0d an=%b seg=%b, expected idx=0 an=1111 seg=11111111",
                     scan_idx, an, seg);
        else passed++;
        rst   = 1'b0;
        n     = 0;
        m_dig = '0;
        m_dp  = '0;
        m_lz  = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            push_model();
            tick();
            exp_v = sb.pop_front();
            total++;
            if ({scan_idx, an, seg} !== exp_v)
                $display("FAIL post_rst edge %0d: got idx=%0d an=%b seg=%b, expected idx=%0d an=%b seg=%b",
                         e, scan_idx, an, seg, exp_v[13:12], exp_v[11:8], exp_v[7:0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz();
        test_dp();
        test_tear();
        test_blank();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
